// File: rtl/sd_audio_pkg.sv
// sd_audio_pkg: shared encodings and widths for the SD audio playback path.
// Offset-binary silence matches the fetch stage's FIFO default word.
package sd_audio_pkg;

    localparam int SAMPLE_W = 16;
    localparam int VOL_W    = 7;

    localparam logic [SAMPLE_W-1:0] SILENCE_OFFSET = 16'h8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        PLAY  = 2'd2
    } state_t;

endpackage

// File: rtl/sd_sigma_delta_dac.sv
// sd_sigma_delta_dac: first-order sigma-delta modulator, 1-bit output.
// The carry out of the 16-bit accumulator is the bitstream.
module sd_sigma_delta_dac
    import sd_audio_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] din,
    output logic                       dout
);

    logic [SAMPLE_W:0] acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else begin
            acc <= {1'b0, acc[SAMPLE_W-1:0]} + {1'b0, din ^ SILENCE_OFFSET};
        end
    end

    assign dout = acc[SAMPLE_W];

endmodule

// File: rtl/sd_sample_player.sv
// sd_sample_player: pops one FIFO word per audio tick, scales it by
// velocity and feeds the sigma-delta DAC; tracks underruns and end-of-stream.
module sd_sample_player
    import sd_audio_pkg::*;
#(
    parameter int SAMPLE_DIV  = 1133,
    parameter int EMPTY_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                play,
    input  logic [VOL_W-1:0]    volume,
    input  logic                fifo_empty,
    input  logic [SAMPLE_W-1:0] fifo_dout,
    output logic                fifo_rd,
    output logic                busy,
    output logic                done,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    output logic [15:0]         underrun_cnt,
    output logic                dac_out
);

    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam int RUN_W = $clog2(EMPTY_LIMIT + 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(EMPTY_LIMIT - 1);

    state_t              state;
    state_t              state_d;
    logic [CNT_W-1:0]    tick_cnt;
    logic [RUN_W-1:0]    empty_run;
    logic                tick;
    logic                rd_d;
    logic                done_d;
    logic                empty_tick;
    logic                play_ok;
    logic                leave_play;
    logic                rd_q;
    logic                cap_vld;
    logic [SAMPLE_W-1:0] dout_q;
    logic signed [23:0]  product;
    logic [SAMPLE_W-1:0] scaled;

    assign tick       = (state != IDLE) && (tick_cnt == TICK_LAST);
    assign play_ok    = (state == PLAY) && play;
    assign leave_play = (state == PLAY) && (state_d != PLAY);
    assign busy       = (state != IDLE);

    // Arithmetic shift keeps floor rounding for negative samples.
    assign product = 24'(signed'(dout_q)) * 24'(signed'({1'b0, volume}));
    assign scaled  = SAMPLE_W'(product >>> 7);

    always_comb begin
        state_d    = state;
        rd_d       = 1'b0;
        done_d     = 1'b0;
        empty_tick = 1'b0;
        unique case (state)
            IDLE: begin
                if (play) state_d = PRIME;
            end
            PRIME: begin
                if (!play) state_d = IDLE;
                else if (!fifo_empty) state_d = PLAY;
            end
            PLAY: begin
                if (!play) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (!fifo_empty) begin
                        rd_d = 1'b1;
                    end else begin
                        empty_tick = 1'b1;
                        if (empty_run == RUN_LAST) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt  <= '0;
            empty_run <= '0;
        end else if (state == IDLE) begin
            tick_cnt  <= '0;
            empty_run <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
            if (rd_d)            empty_run <= '0;
            else if (empty_tick) empty_run <= empty_run + RUN_W'(1);
        end
    end

    // Read pipeline: pop, data returns, capture, scale.
    // Any abort of playback drops the word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_rd      <= 1'b0;
            rd_q         <= 1'b0;
            cap_vld      <= 1'b0;
            dout_q       <= '0;
            done         <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            fifo_rd      <= rd_d;
            rd_q         <= fifo_rd && play_ok;
            cap_vld      <= rd_q && play_ok;
            done         <= done_d;
            sample_valid <= 1'b0;
            if (rd_q && play_ok) dout_q <= fifo_dout;
            if (empty_tick) begin
                sample       <= '0;
                sample_valid <= 1'b1;
            end else if (leave_play) begin
                sample <= '0;
            end else if (cap_vld && play_ok) begin
                sample       <= scaled;
                sample_valid <= 1'b1;
            end
            if (empty_tick && (underrun_cnt != 16'hFFFF))
                underrun_cnt <= underrun_cnt + 16'd1;
        end
    end

    sd_sigma_delta_dac u_dac (
        .clk  (clk),
        .rst  (rst),
        .din  (sample),
        .dout (dac_out)
    );

endmodule

// File: tb/tb_sd_sample_player.sv
// tb_sd_sample_player: randomized playback scenarios against a
// cycle-level behavioural model of the player and a queue-based FIFO.
module tb_sd_sample_player;

    localparam int DIV   = 8;
    localparam int LIMIT = 4;
    localparam int M_IDLE  = 0;
    localparam int M_PRIME = 1;
    localparam int M_PLAY  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        play;
    logic [6:0]  volume;
    logic        fifo_empty;
    logic [15:0] fifo_dout;
    logic        fifo_rd;
    logic        busy;
    logic        done;
    logic [15:0] sample;
    logic        sample_valid;
    logic [15:0] underrun_cnt;
    logic        dac_out;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] fq[$];

    int          m_state = M_IDLE;
    int          m_cnt   = 0;
    int          m_run   = 0;
    int          k       = 0;
    int          pend_due[$];
    logic [15:0] pend_w[$];
    logic        e_rd, e_sv, e_done, e_busy;
    logic [15:0] e_sample;
    int          e_under;

    always #5 clk = ~clk;

    sd_sample_player #(
        .SAMPLE_DIV  (DIV),
        .EMPTY_LIMIT (LIMIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .play         (play),
        .volume       (volume),
        .fifo_empty   (fifo_empty),
        .fifo_dout    (fifo_dout),
        .fifo_rd      (fifo_rd),
        .busy         (busy),
        .done         (done),
        .sample       (sample),
        .sample_valid (sample_valid),
        .underrun_cnt (underrun_cnt),
        .dac_out      (dac_out)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    function automatic logic [15:0] ref_scale(input logic [15:0] w,
                                              input logic [6:0] v);
        int s;
        int p;
        s = $signed(w);
        p = s * int'(v);
        return 16'(p >>> 7);
    endfunction

    task automatic model_reset();
        m_state  = M_IDLE;
        m_cnt    = 0;
        m_run    = 0;
        e_rd     = 1'b0;
        e_sv     = 1'b0;
        e_done   = 1'b0;
        e_busy   = 1'b0;
        e_sample = 16'h0;
        e_under  = 0;
        pend_due.delete();
        pend_w.delete();
    endtask

    task automatic model_step();
        bit tk;
        k++;
        e_rd   = 1'b0;
        e_sv   = 1'b0;
        e_done = 1'b0;
        if (m_state == M_IDLE) begin
            if (play) begin
                m_state = M_PRIME;
                m_cnt   = 0;
                m_run   = 0;
            end
        end else begin
            tk = ((m_cnt % DIV) == DIV - 1);
            m_cnt++;
            if (!play) begin
                if (m_state == M_PLAY) e_sample = 16'h0;
                m_state = M_IDLE;
                pend_due.delete();
                pend_w.delete();
            end else if (m_state == M_PRIME) begin
                if (!fifo_empty) m_state = M_PLAY;
            end else begin
                if (pend_due.size() > 0 && pend_due[0] == k) begin
                    e_sample = ref_scale(pend_w[0], volume);
                    e_sv     = 1'b1;
                    void'(pend_due.pop_front());
                    void'(pend_w.pop_front());
                end
                if (tk) begin
                    if (!fifo_empty) begin
                        e_rd  = 1'b1;
                        m_run = 0;
                        pend_due.push_back(k + 3);
                        pend_w.push_back(fq[0]);
                    end else begin
                        e_sample = 16'h0;
                        e_sv     = 1'b1;
                        if (e_under < 65535) e_under++;
                        m_run++;
                        if (m_run == LIMIT) begin
                            e_done  = 1'b1;
                            m_state = M_IDLE;
                        end
                    end
                end
            end
        end
        e_busy = (m_state != M_IDLE);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    task automatic step();
        @(negedge clk);
        if (!rst) begin
            chk("fifo_rd", fifo_rd, e_rd);
            chk("sample_valid", sample_valid, e_sv);
            chk("done", done, e_done);
            chk("busy", busy, e_busy);
            chk("sample", sample, e_sample);
            chk("underrun_cnt", underrun_cnt, e_under);
        end
        if (fifo_rd && fq.size() > 0) fifo_dout = fq.pop_front();
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic push(input logic [15:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic run_to_idle(input int budget, output int dones,
                               output logic [15:0] first_s);
        bit got_s;
        dones   = 0;
        got_s   = 0;
        first_s = 16'hxxxx;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done) dones++;
            if (sample_valid && !got_s) begin
                got_s   = 1;
                first_s = sample;
            end
            if (!busy) break;
        end
        play = 1'b0;
        chk("idle_reached", busy, 1'b0);
    endtask

    initial begin
        int          d;
        int          cnt;
        logic [15:0] s;
        rst        = 1'b1;
        play       = 1'b0;
        volume     = 7'd0;
        fifo_empty = 1'b1;
        fifo_dout  = 16'h0;
        step();
        step();
        chk("rst_fifo_rd", fifo_rd, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sample", sample, 16'h0);
        chk("rst_valid", sample_valid, 1'b0);
        chk("rst_under", underrun_cnt, 16'h0);
        chk("rst_dac", dac_out, 1'b0);
        rst = 1'b0;
        step();

        volume = 7'd127;
        repeat (3) push(16'h4000);
        play = 1'b1;
        run_to_idle(200, d, s);
        chk("A_done_once", d, 1);
        chk("A_sample", s, 16'h3F80);
        chk("A_under", underrun_cnt, 16'd4);

        volume = 7'd64;
        push(16'h8000);
        play = 1'b1;
        run_to_idle(200, d, s);
        chk("B_sample", s, 16'hC000);
        chk("B_under", underrun_cnt, 16'd8);

        volume = 7'd0;
        push(16'($urandom) | 16'h0001);
        play = 1'b1;
        run_to_idle(200, d, s);
        chk("C_sample", s, 16'h0);

        for (int r = 0; r < 4; r++) begin
            volume = 7'($urandom);
            for (int j = 0; j < 1 + int'($urandom_range(4)); j++)
                push(16'($urandom));
            play = 1'b1;
            run_to_idle(300, d, s);
            chk("R_done_once", d, 1);
        end

        cnt  = 0;
        play = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (fifo_rd) cnt++;
        end
        chk("prime_no_rd", cnt, 0);
        chk("prime_busy", busy, 1'b1);
        chk("prime_under", underrun_cnt, 16'd28);
        push(16'h1234);
        cnt = 0;
        for (int i = 0; i < 3 * DIV; i++) begin
            step();
            if (fifo_rd) begin
                cnt = i;
                break;
            end
        end
        chk("prime_rd_after_tick", fifo_rd, 1'b1);
        run_to_idle(200, d, s);

        for (int j = 0; j < 4; j++) push(16'($urandom));
        volume = 7'($urandom);
        play   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (fifo_rd) break;
        end
        chk("abort_rd_seen", fifo_rd, 1'b1);
        step();
        play = 1'b0;
        cnt  = 0;
        d    = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (sample_valid) cnt++;
            if (done) d++;
        end
        chk("abort_no_valid", cnt, 0);
        chk("abort_no_done", d, 0);
        chk("abort_sample", sample, 16'h0);
        chk("abort_idle", busy, 1'b0);
        fq.delete();
        step();

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(9) == 0) push(16'($urandom));
            if ($urandom_range(39) == 0) play = ~play;
            if ($urandom_range(15) == 0) volume = 7'($urandom);
            step();
        end
        play = 1'b0;
        step();
        step();
        fq.delete();
        step();

        for (int j = 0; j < 6; j++) push(16'($urandom) | 16'h4000);
        volume = 7'd100;
        play   = 1'b1;
        for (int i = 0; i < 20; i++) step();
        rst = 1'b1;
        #1;
        chk("arst_fifo_rd", fifo_rd, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_sample", sample, 16'h0);
        chk("arst_valid", sample_valid, 1'b0);
        chk("arst_under", underrun_cnt, 16'h0);
        chk("arst_dac", dac_out, 1'b0);
        play = 1'b0;
        step();
        step();
        rst = 1'b0;
        fq.delete();
        step();

        cnt = 0;
        for (int i = 0; i < 65536; i++) begin
            step();
            if (dac_out) cnt++;
        end
        chk("dac_duty_50", cnt, 32768);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
